// File: rtl/uart_cmd_initiator_if.sv
// Host-side command/status bundle of the UART nibble initiator.
// The master issues start/cmd; the slave (initiator) reports status.
interface uart_cmd_initiator_if;
    logic       start;
    logic [3:0] cmd;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       ack_err;
    logic       timeout;
    logic [7:0] rx_byte;
    logic [2:0] attempts;

    modport master (
        output start, cmd,
        input  busy, done, ack_ok, ack_err,
        input  timeout, rx_byte, attempts
    );

    modport slave (
        input  start, cmd,
        output busy, done, ack_ok, ack_err,
        output timeout, rx_byte, attempts
    );
endinterface

// File: rtl/uart_cmd_initiator.sv
// Chip-select-gated UART nibble initiator: sends a command nibble,
// waits for the {4'b1010, nibble} acknowledge, retries on failure.
module uart_cmd_initiator #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clk,
    input  logic reset,
    uart_cmd_initiator_if.slave host,
    output logic uart_tx,
    output logic cs,
    input  logic uart_rx
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = ($clog2(CPB) > 0) ? $clog2(CPB) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_TX, S_WAIT,
        S_CHECK, S_GAP, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        R_HUNT, R_START, R_DATA, R_STOP
    } rx_phase_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [3:0]    cmd_q;
    logic [9:0]    frame;
    logic [TW-1:0] to_cnt;
    logic          cnt_last;
    logic          to_fire;
    logic          pass;
    logic          retry;

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    rx_phase_t     rx_phase;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_stop;
    logic          rx_done;

    assign frame    = {1'b1, 4'b0000, cmd_q, 1'b0};
    assign cnt_last = (cnt == BIT_LAST);
    assign pass     = rx_stop && (rx_data == {4'b1010, cmd_q});
    assign retry    = int'(host.attempts) <= MAX_RETRIES;

    // Timeout only fires while hunting; a frame in flight may overrun it.
    assign to_fire = (state == S_WAIT) && (rx_phase == R_HUNT)
                  && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (host.start) state_nxt = S_SETUP;
            S_SETUP: if (cnt_last) state_nxt = S_TX;
            S_TX:    if (cnt_last && bit_idx == 4'd9)
                         state_nxt = S_WAIT;
            S_WAIT: begin
                if (rx_done)      state_nxt = S_CHECK;
                else if (to_fire) state_nxt = retry ? S_GAP : S_DONE;
            end
            S_CHECK: begin
                if (pass)       state_nxt = S_DONE;
                else if (retry) state_nxt = S_GAP;
                else            state_nxt = S_DONE;
            end
            S_GAP:   if (cnt_last) state_nxt = S_SETUP;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx   = 1'b1;
        cs        = 1'b1;
        host.busy = (state != S_IDLE);
        host.done = 1'b0;
        unique case (state)
            S_SETUP, S_WAIT, S_CHECK: cs = 1'b0;
            S_TX: begin
                cs      = 1'b0;
                uart_tx = frame[bit_idx];
            end
            S_DONE:  host.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bit_idx       <= '0;
            cmd_q         <= '0;
            to_cnt        <= '0;
            host.ack_ok   <= 1'b0;
            host.ack_err  <= 1'b0;
            host.timeout  <= 1'b0;
            host.rx_byte  <= '0;
            host.attempts <= '0;
        end else begin
            if (state_nxt != state || cnt_last) cnt <= '0;
            else                                cnt <= cnt + 1'b1;

            if (state != S_TX)  bit_idx <= '0;
            else if (cnt_last)  bit_idx <= bit_idx + 4'd1;

            if (state != S_WAIT)        to_cnt <= '0;
            else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

            if (state == S_IDLE && host.start) begin
                cmd_q        <= host.cmd;
                host.ack_ok  <= 1'b0;
                host.ack_err <= 1'b0;
                host.timeout <= 1'b0;
            end

            // Acceptance zeroes the count and SETUP entry bumps it.
            if (state_nxt == S_SETUP && state != S_SETUP) begin
                if (state == S_IDLE)
                    host.attempts <= 3'd1;
                else if (host.attempts != 3'd7)
                    host.attempts <= host.attempts + 3'd1;
            end

            if (state == S_CHECK) begin
                host.rx_byte <= rx_data;
                if (pass)        host.ack_ok  <= 1'b1;
                else if (!retry) host.ack_err <= 1'b1;
            end

            if (state == S_WAIT && !rx_done && to_fire && !retry)
                host.timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_phase <= R_HUNT;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_stop  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;
            if (state != S_WAIT) begin
                rx_phase <= R_HUNT;
                rx_cnt   <= '0;
                rx_idx   <= '0;
            end else begin
                unique case (rx_phase)
                    R_HUNT: begin
                        if (rx_prev && !rx_s2) begin
                            rx_phase <= R_START;
                            rx_cnt   <= '0;
                        end
                    end
                    R_START: begin
                        if (rx_cnt == HALF_LAST) begin
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                            rx_phase <= rx_s2 ? R_HUNT : R_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (rx_cnt == BIT_LAST) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_idx   <= rx_idx + 3'd1;
                            if (rx_idx == 3'd7) rx_phase <= R_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (rx_cnt == BIT_LAST) begin
                            rx_cnt   <= '0;
                            rx_data  <= rx_shift;
                            rx_stop  <= rx_s2;
                            rx_done  <= 1'b1;
                            rx_phase <= R_HUNT;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    default: rx_phase <= R_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator at 10 clocks per bit.
// u0 allows two retries, u1 allows none; both share clk, reset and rx.
module tb_uart_cmd_initiator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic tx0, cs0, tx1, cs1;
    int total = 0;
    int bad = 0;

    uart_cmd_initiator_if h0();
    uart_cmd_initiator_if h1();

    uart_cmd_initiator #(
        .CLK_FREQ(1000), .BAUD(100),
        .TIMEOUT_CYCLES(200), .MAX_RETRIES(2)
    ) u0 (
        .clk(clk), .reset(reset), .host(h0.slave),
        .uart_tx(tx0), .cs(cs0), .uart_rx(uart_rx)
    );

    uart_cmd_initiator #(
        .CLK_FREQ(1000), .BAUD(100),
        .TIMEOUT_CYCLES(200), .MAX_RETRIES(0)
    ) u1 (
        .clk(clk), .reset(reset), .host(h1.slave),
        .uart_tx(tx1), .cs(cs1), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input bit sel, input logic [3:0] c);
        h0.cmd = c;
        h1.cmd = c;
        if (sel) h1.start = 1'b1;
        else     h0.start = 1'b1;
        @(negedge clk);
        h0.start = 1'b0;
        h1.start = 1'b0;
    endtask

    // Stop bit held 7 clocks: long enough to cover its centre sample.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = stop;
        tick(7);
        uart_rx = 1'b1;
    endtask

    task automatic capture(input bit sel, output logic [9:0] bits,
                           output bit found, output bit cs_low);
        found = 1'b0;
        cs_low = 1'b1;
        bits = '0;
        for (int i = 0; i < 40; i++) begin
            if ((sel ? tx1 : tx0) === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (found) begin
            for (int i = 0; i < 10; i++) begin
                tick(i == 0 ? 4 : 10);
                bits[i] = sel ? tx1 : tx0;
                if ((sel ? cs1 : cs0) !== 1'b0) cs_low = 1'b0;
            end
            tick(6);
        end
    endtask

    task automatic wait_done(input bit sel, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((sel ? h1.done : h0.done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++;
        if ({tx0, cs0, h0.busy, h0.done, h0.ack_ok, h0.ack_err,
             h0.timeout} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=1100000",
                {tx0, cs0, h0.busy, h0.done, h0.ack_ok,
                 h0.ack_err, h0.timeout});
        end
        total++;
        if (h0.rx_byte !== 8'h00 || h0.attempts !== 3'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%0d want=00/0",
                h0.rx_byte, h0.attempts);
        end
        total++;
        if ({tx1, cs1, h1.busy, h1.done} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_u1 got=%b want=1100",
                {tx1, cs1, h1.busy, h1.done});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        logic [9:0] bits;
        bit found, csl, seen;
        int n;
        pulse_start(1'b0, 4'h5);
        total++;
        if ({cs0, h0.busy, tx0} !== 3'b011) begin
            bad++;
            $display("FAIL single_accept got=%b want=011",
                {cs0, h0.busy, tx0});
        end
        n = 0;
        while (tx0 === 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL single_setup got=%0d want=10", n);
        end
        capture(1'b0, bits, found, csl);
        total++;
        if (!found || bits !== 10'h20A || !csl) begin
            bad++;
            $display("FAIL single_frame got=%h/%0b/%0b want=20a/1/1",
                bits, found, csl);
        end
        total++;
        if ({cs0, tx0} !== 2'b01) begin
            bad++;
            $display("FAIL single_wait got=%b want=01", {cs0, tx0});
        end
        tick(30);
        send_rx(8'hA5, 1'b1);
        wait_done(1'b0, seen);
        total++;
        if (!seen || {h0.ack_ok, h0.ack_err, h0.timeout} !== 3'b100) begin
            bad++;
            $display("FAIL single_status got=%0b/%b want=1/100",
                seen, {h0.ack_ok, h0.ack_err, h0.timeout});
        end
        total++;
        if (h0.rx_byte !== 8'hA5 || h0.attempts !== 3'd1) begin
            bad++;
            $display("FAIL single_data got=%h/%0d want=a5/1",
                h0.rx_byte, h0.attempts);
        end
        total++;
        if ({cs0, h0.busy} !== 2'b11) begin
            bad++;
            $display("FAIL single_done_cs got=%b want=11", {cs0, h0.busy});
        end
        tick(1);
        total++;
        if ({h0.busy, h0.done, cs0, h0.ack_ok} !== 4'b0011) begin
            bad++;
            $display("FAIL single_after got=%b want=0011",
                {h0.busy, h0.done, cs0, h0.ack_ok});
        end
        tick(3);
    endtask

    task automatic test_retry();
        logic [9:0] bits;
        bit found, csl, seen;
        int hi;
        pulse_start(1'b0, 4'h5);
        capture(1'b0, bits, found, csl);
        total++;
        if (!found || bits !== 10'h20A) begin
            bad++;
            $display("FAIL retry_frame1 got=%h want=20a", bits);
        end
        tick(30);
        send_rx(8'hA4, 1'b1);
        for (int i = 0; i < 60 && cs0 === 1'b0; i++) tick(1);
        hi = 0;
        while (cs0 === 1'b1 && hi < 40) begin
            hi++;
            tick(1);
        end
        total++;
        if (hi != 10) begin
            bad++;
            $display("FAIL retry_gap got=%0d want=10", hi);
        end
        capture(1'b0, bits, found, csl);
        total++;
        if (!found || bits !== 10'h20A || !csl) begin
            bad++;
            $display("FAIL retry_frame2 got=%h want=20a", bits);
        end
        tick(30);
        send_rx(8'hA5, 1'b1);
        wait_done(1'b0, seen);
        total++;
        if (!seen || h0.ack_ok !== 1'b1 || h0.attempts !== 3'd2) begin
            bad++;
            $display("FAIL retry_done got=%0b/%b/%0d want=1/1/2",
                seen, h0.ack_ok, h0.attempts);
        end
        tick(3);
    endtask

    task automatic test_timeout();
        logic [9:0] bits;
        bit found, csl;
        int w;
        pulse_start(1'b0, 4'hC);
        for (int k = 0; k < 3; k++) begin
            capture(1'b0, bits, found, csl);
            total++;
            if (!found || bits !== 10'h218) begin
                bad++;
                $display("FAIL to_frame%0d got=%h want=218", k, bits);
            end
            w = 0;
            while (cs0 === 1'b0 && w < 400) begin
                w++;
                tick(1);
            end
            total++;
            if (w != 200) begin
                bad++;
                $display("FAIL to_wait%0d got=%0d want=200", k, w);
            end
        end
        total++;
        if ({h0.done, h0.ack_ok, h0.ack_err, h0.timeout} !== 4'b1001
            || h0.attempts !== 3'd3) begin
            bad++;
            $display("FAIL to_status got=%b/%0d want=1001/3",
                {h0.done, h0.ack_ok, h0.ack_err, h0.timeout},
                h0.attempts);
        end
        tick(3);
    endtask

    task automatic test_glitch();
        logic [9:0] bits;
        bit found, csl, seen;
        pulse_start(1'b0, 4'h3);
        capture(1'b0, bits, found, csl);
        total++;
        if (!found || bits !== 10'h206) begin
            bad++;
            $display("FAIL glitch_frame got=%h want=206", bits);
        end
        tick(20);
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(20);
        send_rx(8'hA3, 1'b1);
        wait_done(1'b0, seen);
        total++;
        if (!seen || {h0.ack_ok, h0.ack_err, h0.timeout} !== 3'b100
            || h0.attempts !== 3'd1 || h0.rx_byte !== 8'hA3) begin
            bad++;
            $display("FAIL glitch_done got=%0b/%b/%0d/%h want=1/100/1/a3",
                seen, {h0.ack_ok, h0.ack_err, h0.timeout},
                h0.attempts, h0.rx_byte);
        end
        tick(3);
    endtask

    task automatic test_framing();
        logic [9:0] bits;
        bit found, csl, seen;
        pulse_start(1'b1, 4'h5);
        capture(1'b1, bits, found, csl);
        total++;
        if (!found || bits !== 10'h20A || !csl) begin
            bad++;
            $display("FAIL frm_frame got=%h want=20a", bits);
        end
        tick(30);
        send_rx(8'hA5, 1'b0);
        wait_done(1'b1, seen);
        total++;
        if (!seen || {h1.ack_ok, h1.ack_err, h1.timeout} !== 3'b010) begin
            bad++;
            $display("FAIL frm_status got=%0b/%b want=1/010",
                seen, {h1.ack_ok, h1.ack_err, h1.timeout});
        end
        total++;
        if (h1.rx_byte !== 8'hA5 || h1.attempts !== 3'd1) begin
            bad++;
            $display("FAIL frm_data got=%h/%0d want=a5/1",
                h1.rx_byte, h1.attempts);
        end
        tick(3);
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        bit found, csl, seen;
        int n, lows;
        pulse_start(1'b0, 4'h5);
        tick(3);
        h0.start = 1'b1;
        tick(1);
        h0.start = 1'b0;
        n = 0;
        while (tx0 === 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL mid_setup got=%0d want=6", n);
        end
        tick(53);
        total++;
        if (tx0 !== 1'b0 || cs0 !== 1'b0 || h0.attempts !== 3'd1) begin
            bad++;
            $display("FAIL mid_bit4 got=%b%b/%0d want=00/1",
                tx0, cs0, h0.attempts);
        end
        reset = 1'b1;
        tick(1);
        total++;
        if ({tx0, cs0, h0.busy, h0.done} !== 4'b1100
            || h0.attempts !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%0d want=1100/0",
                {tx0, cs0, h0.busy, h0.done}, h0.attempts);
        end
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (tx0 !== 1'b1 || cs0 !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL mid_no_resume got=%0d want=0", lows);
        end
        pulse_start(1'b0, 4'h5);
        capture(1'b0, bits, found, csl);
        total++;
        if (!found || bits !== 10'h20A) begin
            bad++;
            $display("FAIL mid_frame got=%h want=20a", bits);
        end
        tick(30);
        send_rx(8'hA5, 1'b1);
        wait_done(1'b0, seen);
        total++;
        if (!seen || h0.ack_ok !== 1'b1 || h0.attempts !== 3'd1) begin
            bad++;
            $display("FAIL mid_done got=%0b/%b/%0d want=1/1/1",
                seen, h0.ack_ok, h0.attempts);
        end
        tick(3);
    endtask

    initial begin
        h0.start = 1'b0;
        h1.start = 1'b0;
        h0.cmd = 4'h0;
        h1.cmd = 4'h0;
        test_reset();
        test_single();
        test_retry();
        test_timeout();
        test_glitch();
        test_framing();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
- Initiator end of the chip-select-gated UART nibble link.
- Asserts the active-low `cs`, transmits a command nibble as an 8N1 byte, then waits for the responder's acknowledge byte {4'b1010, nibble}.
- Retries on a bad acknowledge or a timeout, and reports a single completion status.
- Lets an FPGA drive a remote LED/nibble responder in place of an external microcontroller.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 9600: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (5208 at defaults).
- TIMEOUT_CYCLES, 200_000: clocks allowed in WAIT_ACK before an attempt times out.
- MAX_RETRIES, 3: extra attempts after the first; total attempts = MAX_RETRIES+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- cmd  in  4  command nibble, latched on acceptance.
- uart_tx  out  1  serial line to the responder's RX; idle high.
- cs  out  1  chip select to the responder, active low.
- uart_rx  in  1  serial line from the responder's TX; asynchronous.
- busy  out  1  high from the cycle after acceptance until the cycle after done.
- done  out  1  one-cycle completion pulse.
- ack_ok  out  1  status: valid acknowledge received.
- ack_err  out  1  status: final attempt got a wrong byte or a framing error.
- timeout  out  1  status: final attempt timed out.
- rx_byte  out  8  last byte received in WAIT_ACK.
- attempts  out  3  number of transmissions made for the current or last request.

Behaviour:
- Reset (synchronous): at the next edge, uart_tx=1, cs=1, busy=0, done=0, ack_ok=0, ack_err=0, timeout=0, rx_byte=0, attempts=0, FSM=IDLE, all counters cleared. Reset mid-operation aborts immediately; no partial frame resumes.
- Acceptance: start=1 in IDLE latches cmd, clears ack_ok/ack_err/timeout, sets attempts=0, and enters SETUP. start in any other state is ignored.
- SETUP: cs=0 and uart_tx=1 for CLKS_PER_BIT clocks; attempts increments on entry.
- TX: frame payload is {4'b0000, cmd}, sent LSB first. Start bit 0, 8 data bits, stop bit 1, each exactly CLKS_PER_BIT clocks (10*CLKS_PER_BIT total). cs stays 0.
- WAIT_ACK: cs stays 0, uart_tx=1. Timeout counter starts at 0 on entry.
  - uart_rx passes through a 2-FF synchronizer; a falling edge starts hunting.
  - Start bit is re-checked at CLKS_PER_BIT/2. If high, it is a false start and hunting resumes; glitches shorter than a half bit are ignored.
  - Data is sampled at bit centres, LSB first. The stop bit is sampled at its centre.
  - Timeout fires only while hunting (no frame in progress). A frame already in progress completes even past TIMEOUT_CYCLES.
  - uart_rx is ignored in every other state.
- CHECK (1 cycle): rx_byte is updated with the received byte.
  - Pass: stop bit = 1 and byte == {4'b1010, cmd}.
  - Anything else is a bad attempt (bad byte or framing error).
- On pass: go to DONE with ack_ok=1.
- On bad attempt or timeout:
  - If attempts <= MAX_RETRIES: go to GAP (cs=1 for CLKS_PER_BIT clocks), then SETUP.
  - Otherwise go to DONE with ack_err=1 (last failure was a bad byte) or timeout=1 (last failure was a timeout). Exactly one status bit is set.
- DONE: cs=1, done=1 for one cycle, then IDLE. busy falls in the cycle after done. Status bits hold until the next acceptance.
- start asserted on the cycle done is high is ignored; the earliest new acceptance is the first IDLE cycle.
- attempts saturates at its 3-bit range; the MAX_RETRIES legal range is 0..6.

Test Plan (CLK_FREQ=1000, BAUD=100 → CLKS_PER_BIT=10; TIMEOUT_CYCLES=200):
- start, cmd=4'h5; responder sends 0xA5 30 clocks after the stop bit → uart_tx bits 0,1,0,1,0,0,0,0,0,1 at 10 clocks each, cs low from acceptance+1 through CHECK; done pulse with ack_ok=1, rx_byte=8'hA5, attempts=1; cs=1 after.
- cmd=4'h5; first reply 0xA4, second reply 0xA5 → cs high exactly 10 clocks between attempts, second frame identical to first; done with ack_ok=1, attempts=2.
- MAX_RETRIES=2, cmd=4'hC, no reply → 3 frames, each WAIT_ACK lasting 200 clocks; done with timeout=1, ack_ok=0, ack_err=0, attempts=3.
- In WAIT_ACK, 2-clock low glitch on uart_rx, then valid 0xA3 with cmd=4'h3 → glitch ignored; ack_ok=1, attempts=1.
- Reply 0xA5 with stop bit driven 0 and MAX_RETRIES=0 → done with ack_err=1, rx_byte=8'hA5, attempts=1.
- Reset asserted mid-TX (data bit 4) → next edge uart_tx=1, cs=1, busy=0, done=0. start during busy (before the reset) produces no second frame. New start after reset completes normally.
